// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver
//   Receive-side framer for the host<->FPGA UART link. Rebuilds {header, message} frames from
//   the uart_rx byte stream (MSB byte first), decodes STALL/UNSTALL control headers and exports
//   the peer's flow-control state.
//
//   Optional feature: define UART_RX_TIMEOUT_EN to discard a partial frame after
//   TIMEOUT_CYCLES idle clocks. Without it, timeout_out is tied 0 and partial frames wait forever.
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous reset, active high
//   ll_valid_in      byte available from uart_rx
//   ll_byte_in       received byte
//   ll_ready_out     framer accepts a byte this cycle
//   frame_valid_out  complete data frame held on outputs
//   frame_ready_in   consumer takes frame
//   header_out       header of held frame
//   message_out      payload of held frame
//   raw_flag_out     RAW flag (header_out[2]) of held frame
//   peer_stalled_out peer has sent STALL and not yet UNSTALL
//   ctrl_error_out   1-cycle pulse on a header with bits [7] and [6] both set
//   timeout_out      1-cycle pulse when a partial frame is discarded on idle
module uart_frame_receiver #(
    parameter int unsigned MESSAGE_SIZE   = 512,
    parameter int unsigned HEADER_SIZE    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    ll_valid_in,
    input  logic [7:0]              ll_byte_in,
    output logic                    ll_ready_out,
    output logic                    frame_valid_out,
    input  logic                    frame_ready_in,
    output logic [HEADER_SIZE-1:0]  header_out,
    output logic [MESSAGE_SIZE-1:0] message_out,
    output logic                    raw_flag_out,
    output logic                    peer_stalled_out,
    output logic                    ctrl_error_out,
    output logic                    timeout_out
);

    localparam int unsigned MSG_BYTES = MESSAGE_SIZE / 8;
    localparam int unsigned HDR_BYTES = HEADER_SIZE / 8;
    localparam int unsigned MAX_BYTES = (HDR_BYTES > MSG_BYTES) ? HDR_BYTES : MSG_BYTES;
    localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {StHeader, StPayload, StHold} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [HEADER_SIZE-1:0]  hdr_q, hdr_next;
    logic [MESSAGE_SIZE-1:0] msg_q, msg_next;
    logic [HEADER_SIZE-1:0]  header_q;
    logic [MESSAGE_SIZE-1:0] message_q;
    logic                    stalled_q;
    logic                    ctrl_error_q;
    logic                    byte_acc;
    logic                    hdr_last;
    logic                    msg_last;
    logic                    idle_expire;

    assign byte_acc = ll_valid_in && ll_ready_out;
    assign hdr_last = (cnt_q == CNT_W'(HDR_BYTES - 1));
    assign msg_last = (cnt_q == CNT_W'(MSG_BYTES - 1));
    // Shifted values including the byte on the bus; the width cast drops the oldest byte.
    assign hdr_next = HEADER_SIZE'({hdr_q, ll_byte_in});
    assign msg_next = MESSAGE_SIZE'({msg_q, ll_byte_in});

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_run;
    logic              timeout_q;

    // A HEADER state with no bytes collected is simply idle, not a stuck partial frame.
    assign idle_run    = (state_q == StPayload) || ((state_q == StHeader) && (cnt_q != '0));
    assign idle_expire = idle_run && !byte_acc && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign idle_d      = (!idle_run || byte_acc || idle_expire) ? '0 : idle_q + IDLE_W'(1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= idle_expire;
        end
    end

    assign timeout_out = timeout_q;
`else
    assign idle_expire = 1'b0;
    assign timeout_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StHeader;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StHeader: begin
                if (byte_acc) begin
                    if (hdr_last) begin
                        cnt_d = '0;
                        if (hdr_next[7:6] == 2'b00) state_d = StPayload;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StPayload: begin
                if (byte_acc) begin
                    if (msg_last) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StHold: begin
                if (frame_ready_in) begin
                    state_d = StHeader;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StHeader;
                cnt_d   = '0;
            end
        endcase
        if (idle_expire) begin
            state_d = StHeader;
            cnt_d   = '0;
        end
    end

    // Outputs decoded from state
    always_comb begin
        ll_ready_out    = (state_q != StHold);
        frame_valid_out = (state_q == StHold);
    end

    // Shift registers, held frame and control-header side effects
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hdr_q        <= '0;
            msg_q        <= '0;
            header_q     <= '0;
            message_q    <= '0;
            stalled_q    <= 1'b0;
            ctrl_error_q <= 1'b0;
        end else begin
            ctrl_error_q <= 1'b0;
            if (byte_acc && (state_q == StHeader)) begin
                hdr_q <= hdr_next;
                if (hdr_last) begin
                    case (hdr_next[7:6])
                        2'b10:   stalled_q    <= 1'b1;
                        2'b01:   stalled_q    <= 1'b0;
                        2'b11:   ctrl_error_q <= 1'b1;
                        default: ;
                    endcase
                end
            end
            if (byte_acc && (state_q == StPayload)) begin
                msg_q <= msg_next;
                if (msg_last) begin
                    header_q  <= hdr_q;
                    message_q <= msg_next;
                end
            end
        end
    end

    assign header_out       = header_q;
    assign message_out      = message_q;
    assign raw_flag_out     = header_q[2];
    assign peer_stalled_out = stalled_q;
    assign ctrl_error_out   = ctrl_error_q;

endmodule
